// File: rtl/grayscale_pipe.sv
// RGB-to-luma front end of the edge filter: pops 24-bit pixels, weights and sums them in two
// pipeline stages, and pushes one luma byte per pixel while tracking the frame position.
module grayscale_pipe #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int W_R    = 77,
  parameter int W_G    = 150,
  parameter int W_B    = 29
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  out_din,
  output logic        frame_done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [7:0] WR = W_R[7:0];
  localparam logic [7:0] WG = W_G[7:0];
  localparam logic [7:0] WB = W_B[7:0];

  function automatic logic [7:0] round_sat(input logic [17:0] sum);
    logic [9:0] l;
    l = sum[17:8];
    if (l > 10'd255) return 8'hFF;
    return l[7:0];
  endfunction

  logic            vld_p0_q, vld_p1_q;
  logic [15:0]     pr_p0_q, pg_p0_q, pb_p0_q;
  logic [7:0]      luma_p1_q;
  logic [17:0]     sum_p1;
  logic            adv_p0, adv_p1;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;

  // A stage may advance when it is empty or when its successor takes its contents.
  assign adv_p1    = !vld_p1_q || !out_full;
  assign adv_p0    = !vld_p0_q || adv_p1;
  assign in_rd_en  = reset && !in_empty && adv_p0;
  assign out_wr_en = vld_p1_q && !out_full;
  assign out_din   = luma_p1_q;
  assign sum_p1    = 18'(pr_p0_q) + 18'(pg_p0_q) + 18'(pb_p0_q) + 18'd128;

  // Stage A -> B: weighted products (data only, no reset needed)
  always_ff @(posedge clock) begin
    if (adv_p0) begin
      pr_p0_q <= 16'(in_dout[23:16]) * 16'(WR);
      pg_p0_q <= 16'(in_dout[15:8])  * 16'(WG);
      pb_p0_q <= 16'(in_dout[7:0])   * 16'(WB);
    end
  end

  // Stage B -> output: rounded, saturated luma plus valids
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      luma_p1_q <= 8'h00;
    end else begin
      if (adv_p0) vld_p0_q <= in_rd_en;
      if (adv_p1) begin
        vld_p1_q  <= vld_p0_q;
        luma_p1_q <= round_sat(sum_p1);
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (out_wr_en) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  assign frame_done = out_wr_en && (x_q == XMAX) && (y_q == YMAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed and randomized bench for grayscale_pipe on a 4x3 frame, checked against a
// queue-based luma model.
module tb_grayscale_pipe;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int FPIX = FW * FH;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_rd_en;
  logic        in_empty = 1'b1;
  logic [23:0] in_dout = 24'h0;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [7:0]  out_din;
  logic        frame_done;

  grayscale_pipe #(.WIDTH(FW), .HEIGHT(FH), .W_R(77), .W_G(150), .W_B(29)) dut (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
    .in_dout(in_dout), .out_wr_en(out_wr_en), .out_full(out_full),
    .out_din(out_din), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [23:0] src_q[$];
  logic [7:0]  exp_q[$];
  int          popc_q[$];
  logic [7:0]  got_q[$];
  int cyc = 0;
  int wr_idx = 0;
  int fd_cnt = 0;
  bit chk_lat = 1'b0;

  function automatic logic [7:0] ref_luma(input logic [23:0] px);
    int l;
    l = (int'(px[23:16]) * 77 + int'(px[15:8]) * 150 + int'(px[7:0]) * 29 + 128) / 256;
    if (l > 255) l = 255;
    return 8'(l);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit emp, input bit full);
    logic [7:0] e;
    int pc;
    in_empty = emp || (src_q.size() == 0);
    in_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
    out_full = full;
    @(negedge clock);
    cyc++;
    check("rd_while_empty", 32'(in_rd_en & in_empty), 0);
    check("wr_while_full", 32'(out_wr_en & out_full), 0);
    if (out_wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        pc = popc_q.pop_front();
        check("luma", 32'(out_din), 32'(e));
        if (chk_lat) check("latency", cyc - pc, 2);
        check("frame_done_wr", 32'(frame_done), 32'(wr_idx % FPIX == FPIX - 1));
        got_q.push_back(out_din);
        wr_idx++;
        if (frame_done) fd_cnt++;
      end
    end else begin
      check("frame_done_idle", 32'(frame_done), 0);
    end
    if (in_rd_en) begin
      exp_q.push_back(ref_luma(in_dout));
      popc_q.push_back(cyc);
      void'(src_q.pop_front());
    end
    check("inflight_le2", 32'(exp_q.size() <= 2), 1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    exp_q.delete();
    popc_q.delete();
    got_q.delete();
    wr_idx = 0;
    fd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      in_empty = 1'b0;
      @(negedge clock);
      check("rst_in_rd_en", 32'(in_rd_en), 0);
      check("rst_out_wr_en", 32'(out_wr_en), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_out_din", 32'(out_din), 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && g < 200) begin
      drive(1'b0, 1'b0);
      g++;
    end
    check(tag, 32'(src_q.size() + exp_q.size()), 0);
  endtask

  initial begin
    logic [23:0] t2_px[5];
    logic [7:0]  t2_exp[5];
    int g;
    t2_px  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
    t2_exp = '{8'h4D, 8'h95, 8'h1D, 8'hFF, 8'h00};

    // 1: reset, then idle with empty input
    #1;
    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0);
      check("idle_no_write", 32'(wr_idx), 0);
    end

    // 2: primaries back-to-back, fixed two-cycle latency
    chk_lat = 1'b1;
    foreach (t2_px[i]) src_q.push_back(t2_px[i]);
    drain("t2_drain");
    chk_lat = 1'b0;
    check("t2_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check("t2_const", 32'(got_q[i]), 32'(t2_exp[i]));

    // 3: 16 pixels with output full for cycles 5..12
    got_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(24'($urandom));
    for (int i = 0; i < 14; i++) drive(1'b0, (i >= 5 && i <= 12));
    drain("t3_drain");
    check("t3_count", got_q.size(), 16);

    // 4: two whole frames after a fresh reset
    do_reset(2);
    for (int i = 0; i < 2 * FPIX; i++) src_q.push_back(24'($urandom));
    drain("t4_drain");
    check("t4_writes", wr_idx, 2 * FPIX);
    check("t4_frame_pulses", fd_cnt, 2);

    // 5: reset with two pixels stuck in flight mid-frame
    for (int i = 0; i < 5; i++) src_q.push_back(24'($urandom));
    drain("t5_pre_drain");
    src_q.push_back(24'hABCDEF);
    src_q.push_back(24'h00FFFF);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    check("t5_inflight", exp_q.size(), 2);
    do_reset(1);
    src_q.push_back(24'h123456);
    for (int i = 1; i < FPIX; i++) src_q.push_back(24'($urandom));
    drain("t5_drain");
    check("t5_writes", wr_idx, FPIX);
    check("t5_frame_pulses", fd_cnt, 1);
    if (got_q.size() != 0) check("t5_first", 32'(got_q[0]), 32'(ref_luma(24'h123456)));

    // 6: random stalls on both sides
    got_q.delete();
    for (int i = 0; i < 10000; i++) src_q.push_back(24'($urandom));
    g = 0;
    while (src_q.size() != 0 && g < 80000) begin
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      g++;
    end
    drain("t6_drain");
    check("t6_count", got_q.size(), 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
